int_arbiter: RTL and testbench
==============================

// Module: int_arbiter
// PURPOSE
//   Collects N external interrupt lines and arbitrates them into the single Ireq/Iack
//   handshake of the multicycle CPU controller. Sits between peripherals and the
//   controller/CP0: latches edges as pending, applies a per-source mask and the global
//   CP0 interrupt enable, and presents one winner ID for the Cause register.
//   Arbitration is fixed-priority or round-robin, selected by parameter.
// PARAMETERS
//   N_SRC   8   number of interrupt sources (2..16)
//   ID_W    3   width of int_id; must equal clog2(N_SRC)
//   RR      0   0 = fixed priority (lowest index wins); 1 = round-robin
// PORTS
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   irq_in       in   N_SRC  raw interrupt lines, asynchronous, rising-edge triggered
//   int_enable   in   1      global enable from CP0 (cleared by syscall/int entry, set by eret)
//   mask_we      in   1      write strobe for mask register
//   mask_wdata   in   N_SRC  new mask value (1 = source enabled)
//   iack         in   1      controller acknowledge, one-cycle pulse
//   ireq         out  1      interrupt request to controller
//   int_id       out  ID_W   index of requesting source; valid while ireq=1
//   mask_out     out  N_SRC  current mask register
//   pending_out  out  N_SRC  current pending bits, for CP0 readback
// BEHAVIOUR
//   Reset (async): ireq=0, int_id=0, mask=0, pending=0, sync flops=0, rr_ptr=0, state=IDLE.
//   Input path: 2-flop synchronizer per line (s1, s2), plus s2_d. edge = s2 & ~s2_d.
//     irq_in first sampled high at edge k -> pending bit set at edge k+2 -> ireq high
//     after edge k+3 if eligible. A line held high sets pending only once.
//   eligible = pending & mask & {N_SRC{int_enable}}.
//   Winner: RR=0 lowest eligible index. RR=1 first eligible index at or above rr_ptr,
//     wrapping modulo N_SRC.
//   FSM:
//     IDLE: if eligible!=0 -> latch winner into int_id, ireq<=1, go REQ.
//     REQ:  ireq and int_id held stable.
//           If iack=1: pending[int_id]<=0, ireq<=0, go GAP.
//             RR=1: rr_ptr <= int_id+1, wrapping to 0 at N_SRC.
//           Else if eligible[int_id]=0 (masked or int_enable dropped): ireq<=0, go IDLE;
//             the pending bit is kept.
//     GAP:  one cycle, ireq=0; go IDLE. Guarantees ireq low for >=1 cycle between requests.
//   iack outside REQ is ignored; state and pending are unchanged.
//   Simultaneous set and clear on the same pending bit: set wins, so the bit stays 1.
//   mask_we: mask<=mask_wdata at the edge. A mask change in REQ takes effect via the
//     eligible check on the next cycle.
//   Higher-priority arrival during REQ does not preempt; int_id is stable until
//     iack or withdrawal.
//   int_id is 0 whenever ireq=0.
//   Reset mid-REQ: ireq drops immediately (async) and all pending state is lost.
// TESTING
//   T1: mask=0xFF, int_enable=1, irq_in[5] 0->1 -> ireq=1 with int_id=5 four edges
//       later; iack pulse -> ireq=0 next cycle, pending=0.
//   T2: RR=0, irq_in[6] and irq_in[2] rise same cycle -> int_id=2; after iack and GAP,
//       a second request with int_id=6.
//   T3: RR=1, lines 0,1,2 kept re-pending after each ack -> int_id sequence 0,1,2,0.
//   T4: int_enable=0 with irq_in[3] edge -> pending_out=0x08, ireq stays 0; set
//       int_enable=1 -> ireq with int_id=3 next cycle.
//   T5: in REQ with int_id=4, write mask=0xEF -> ireq=0 next cycle, pending[4] still 1;
//       restore mask=0xFF -> request reissued.
//   T6: new edge on line 1 in the same cycle as iack for int_id=1 -> pending[1] remains
//       1 and a new request follows GAP; assert reset during REQ -> ireq=0 asynchronously.

Source files
------------

// File: rtl/int_arbiter.sv
// Interrupt arbiter: synchronizes N external lines, latches rising edges as
// pending, qualifies them with a per-source mask and the global enable, and
// hands one winner to the controller over an ireq/iack handshake.
module int_arbiter #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = 3,
  parameter bit          RR    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             int_enable,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             iack,
  output logic             ireq,
  output logic [ID_W-1:0]  int_id,
  output logic [N_SRC-1:0] mask_out,
  output logic [N_SRC-1:0] pending_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;
  logic [N_SRC-1:0] sync2_d;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic             ireq_nxt;
  logic [ID_W-1:0]  int_id_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_ptr_nxt;
  logic [ID_W-1:0]  base;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  winner;
  logic             found;

  assign rise        = sync2 & ~sync2_d;
  assign eligible    = pending & mask & {N_SRC{int_enable}};
  assign mask_out    = mask;
  assign pending_out = pending;

  // Input synchronizers, edge history and mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
      mask    <= '0;
    end else begin
      sync1   <= irq_in;
      sync2   <= sync1;
      sync2_d <= sync2;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Winner search: scan upward from base, wrapping; base is 0 for fixed priority
  always_comb begin
    base   = RR ? rr_ptr : '0;
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      cand = ID_W'((32'(base) + i) % N_SRC);
      if (!found && eligible[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Handshake state, request outputs, pending bits and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ireq    <= 1'b0;
      int_id  <= '0;
      pending <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      ireq    <= ireq_nxt;
      int_id  <= int_id_nxt;
      pending <= pending_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  // Next-state logic; a new edge on the same cycle as a clear keeps the bit set
  always_comb begin
    state_nxt  = state;
    ireq_nxt   = ireq;
    int_id_nxt = int_id;
    rr_ptr_nxt = rr_ptr;
    clr        = '0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          ireq_nxt   = 1'b1;
          int_id_nxt = winner;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        if (iack) begin
          clr        = N_SRC'(1) << int_id;
          ireq_nxt   = 1'b0;
          int_id_nxt = '0;
          state_nxt  = GAP;
          if (RR) begin
            rr_ptr_nxt = (32'(int_id) == N_SRC - 1) ? '0 : int_id + ID_W'(1);
          end
        end else if (!eligible[int_id]) begin
          ireq_nxt   = 1'b0;
          int_id_nxt = '0;
          state_nxt  = IDLE;
        end
      end
      GAP: begin
        ireq_nxt   = 1'b0;
        int_id_nxt = '0;
        state_nxt  = IDLE;
      end
      default: begin
        ireq_nxt   = 1'b0;
        int_id_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
    pending_nxt = (pending & ~clr) | rise;
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: a fixed-priority and a round-robin instance share
// stimulus and are compared every cycle against a behavioural model.
module tb_int_arbiter;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_in;
  logic          int_enable;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic          iack0, iack1;
  logic          ireq0, ireq1;
  logic [IW-1:0] id0, id1;
  logic [N-1:0]  mask0, mask1, pend0, pend1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_arbiter #(.N_SRC(N), .ID_W(IW), .RR(1'b0)) dut0 (
    .clk(clk), .reset(reset), .irq_in(irq_in), .int_enable(int_enable),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .iack(iack0),
    .ireq(ireq0), .int_id(id0), .mask_out(mask0), .pending_out(pend0)
  );

  int_arbiter #(.N_SRC(N), .ID_W(IW), .RR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .irq_in(irq_in), .int_enable(int_enable),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .iack(iack1),
    .ireq(ireq1), .int_id(id1), .mask_out(mask1), .pending_out(pend1)
  );

  // Reference model: line samples of the last three edges, per-instance request view
  bit [N-1:0] h1, h2, h3;
  bit [N-1:0] m_mask;
  bit [N-1:0] m_pend [2];
  bit         m_on   [2];
  bit         m_gap  [2];
  int         m_id   [2];
  int         m_ptr  [2];

  function automatic int pick(bit [N-1:0] elig, int base);
    int i;
    for (int off = 0; off < N; off++) begin
      i = (base + off) % N;
      if (elig[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    h1 = '0; h2 = '0; h3 = '0; m_mask = '0;
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0; m_on[m] = 1'b0; m_gap[m] = 1'b0; m_id[m] = 0; m_ptr[m] = 0;
    end
  endtask

  task automatic model_edge();
    bit [N-1:0] rise, elig, clr;
    bit ack;
    rise = h2 & ~h3;
    for (int m = 0; m < 2; m++) begin
      elig = m_pend[m] & m_mask & {N{int_enable}};
      ack  = (m == 0) ? iack0 : iack1;
      clr  = '0;
      if (m_on[m]) begin
        if (ack) begin
          clr[m_id[m]] = 1'b1;
          m_on[m]  = 1'b0;
          m_gap[m] = 1'b1;
          if (m == 1) m_ptr[m] = (m_id[m] + 1) % N;
        end else if (!elig[m_id[m]]) begin
          m_on[m] = 1'b0;
        end
      end else if (m_gap[m]) begin
        m_gap[m] = 1'b0;
      end else if (elig != '0) begin
        m_on[m] = 1'b1;
        m_id[m] = pick(elig, (m == 1) ? m_ptr[m] : 0);
      end
      m_pend[m] = (m_pend[m] & ~clr) | rise;
    end
    if (mask_we) m_mask = mask_wdata;
    h3 = h2; h2 = h1; h1 = irq_in;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ireq0", 32'(ireq0), 32'(m_on[0]));
    check("id0",   32'(id0),   m_on[0] ? 32'(m_id[0]) : 32'd0);
    check("pend0", 32'(pend0), 32'(m_pend[0]));
    check("mask0", 32'(mask0), 32'(m_mask));
    check("ireq1", 32'(ireq1), 32'(m_on[1]));
    check("id1",   32'(id1),   m_on[1] ? 32'(m_id[1]) : 32'd0);
    check("pend1", 32'(pend1), 32'(m_pend[1]));
    check("mask1", 32'(mask1), 32'(m_mask));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_req(int m);
    for (int c = 0; c < 20 && !m_on[m]; c++) step();
  endtask

  task automatic pulse_ack();
    iack0 = 1'b1; iack1 = 1'b1;
    step();
    iack0 = 1'b0; iack1 = 1'b0;
  endtask

  task automatic write_mask(bit [N-1:0] v);
    mask_we = 1'b1; mask_wdata = v;
    step();
    mask_we = 1'b0;
  endtask

  int exp_seq [4];

  initial begin
    reset = 1'b1; irq_in = '0; int_enable = 1'b0; mask_we = 1'b0;
    mask_wdata = '0; iack0 = 1'b0; iack1 = 1'b0;
    model_reset();
    #1;
    check("rst_ireq", 32'(ireq0), 32'd0);
    check("rst_id",   32'(id0),   32'd0);
    check("rst_mask", 32'(mask0), 32'd0);
    check("rst_pend", 32'(pend1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // T1: single source, four-edge latency, ack clears pending
    int_enable = 1'b1;
    write_mask(8'hFF);
    check("t1_mask", 32'(mask0), 32'hFF);
    irq_in[5] = 1'b1;
    step(); step(); step();
    check("t1_pend", 32'(pend0), 32'h20);
    check("t1_noreq", 32'(ireq0), 32'd0);
    step();
    check("t1_ireq", 32'(ireq0), 32'd1);
    check("t1_id", 32'(id0), 32'd5);
    pulse_ack();
    check("t1_drop", 32'(ireq0), 32'd0);
    check("t1_clr", 32'(pend0), 32'd0);

    // T2: simultaneous 6 and 2, fixed priority serves 2 then 6
    irq_in = '0;
    repeat (4) step();
    irq_in = 8'h44;
    wait_req(0);
    check("t2_first", 32'(id0), 32'd2);
    check("t2_rr_first", 32'(id1), 32'd6);
    pulse_ack();
    step();
    check("t2_gap", 32'(ireq0), 32'd0);
    step();
    check("t2_second_req", 32'(ireq0), 32'd1);
    check("t2_second", 32'(id0), 32'd6);
    pulse_ack();
    irq_in = '0;
    repeat (4) step();

    // T3: round-robin rotation over re-pended lines 0,1,2
    do_reset();
    write_mask(8'hFF);
    irq_in = 8'h07;
    exp_seq = '{0, 1, 2, 0};
    for (int k = 0; k < 4; k++) begin
      wait_req(1);
      check("t3_ireq", 32'(ireq1), 32'd1);
      check("t3_id", 32'(id1), 32'(exp_seq[k]));
      pulse_ack();
      irq_in[exp_seq[k]] = 1'b0;
      step();
      irq_in[exp_seq[k]] = 1'b1;
    end
    irq_in = '0;
    repeat (4) step();

    // T4: pending held while globally disabled, request on enable
    do_reset();
    write_mask(8'hFF);
    int_enable = 1'b0;
    irq_in[3] = 1'b1;
    step(); step(); step();
    check("t4_pend", 32'(pend0), 32'h08);
    step(); step();
    check("t4_noreq", 32'(ireq0), 32'd0);
    int_enable = 1'b1;
    step();
    check("t4_ireq", 32'(ireq0), 32'd1);
    check("t4_id0", 32'(id0), 32'd3);
    check("t4_id1", 32'(id1), 32'd3);
    pulse_ack();

    // T5: masking the active source withdraws; unmasking reissues
    irq_in[4] = 1'b1;
    wait_req(0);
    check("t5_id", 32'(id0), 32'd4);
    write_mask(8'hEF);
    check("t5_hold", 32'(ireq0), 32'd1);
    step();
    check("t5_withdraw", 32'(ireq0), 32'd0);
    check("t5_pend_kept", 32'(pend0 & 8'h10), 32'h10);
    write_mask(8'hFF);
    step();
    check("t5_reissue", 32'(ireq0), 32'd1);
    check("t5_reissue_id", 32'(id0), 32'd4);
    pulse_ack();

    // T6: new edge coincident with ack keeps pending; async reset mid-request
    irq_in[1] = 1'b1;
    wait_req(0);
    check("t6_id", 32'(id0), 32'd1);
    irq_in[1] = 1'b0;
    step();
    irq_in[1] = 1'b1;
    step(); step();
    pulse_ack();
    check("t6_pend_kept", 32'(pend0 & 8'h02), 32'h02);
    check("t6_drop", 32'(ireq0), 32'd0);
    step();
    step();
    check("t6_rereq", 32'(ireq0), 32'd1);
    check("t6_rereq_id", 32'(id0), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("t6_async_ireq0", 32'(ireq0), 32'd0);
    check("t6_async_ireq1", 32'(ireq1), 32'd0);
    check("t6_async_pend", 32'(pend0), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // Random traffic against the model
    irq_in = '0;
    for (int c = 0; c < 400; c++) begin
      irq_in     = irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
      int_enable = ($urandom_range(0, 9) != 0);
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_wdata = N'($urandom);
      iack0      = ($urandom_range(0, 2) == 0);
      iack1      = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
